mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle main control FSM for the RV32I core. It sits directly upstream of `aludec`: it sequences each instruction through fetch, decode, execute, memory and writeback, and drives `ALUOp` into `aludec` together with every datapath select and write strobe. Memory accesses use a ready handshake so that fetch, load and store can stall for a variable number of cycles.

## Interface
Parameters: none.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `op` input 7: opcode field from the instruction register; stable from DECODE until the instruction retires.
- `Zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: `(Branch & Zero) | PCUpdate`.
- `Branch` output 1: branch-compare cycle.
- `PCUpdate` output 1: unconditional PC load.
- `IRWrite` output 1: latch the fetched instruction and OldPC.
- `RegWrite` output 1: register file write.
- `MemWrite` output 1: data memory write.
- `AdrSrc` output 1: memory address select (0 = PC, 1 = Result).
- `ResultSrc` output 2: result select (00 = ALUOut, 01 = Data, 10 = ALUResult).
- `ALUSrcA` output 2: ALU A select (00 = PC, 01 = OldPC, 10 = rs1 register).
- `ALUSrcB` output 2: ALU B select (00 = rs2 register, 01 = ImmExt, 10 = constant 4).
- `ALUOp` output 2: to `aludec` (00 = add, 01 = sub, 10 = decode funct).
- `ImmSrc` output 2: immediate format (00 = I, 01 = S, 10 = B, 11 = J). Combinational from `op`.
- `illegal` output 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `retire` output 1: one-cycle pulse on the final cycle of each instruction.

## Operation
- Moore FSM. Every output not listed for a state is 0.
- **FETCH:** `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite` and `PCUpdate` are asserted only when `mem_ready`=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- **DECODE:** `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (branch/jump target goes into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - anything else → FETCH, with `illegal`=1 and `retire`=1 in this cycle.
- **MEMADR:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Goes to MEMREAD if `op`=0000011, else MEMWRITE.
- **MEMREAD:** `ResultSrc`=00, `AdrSrc`=1. Stays until `mem_ready`, then MEMWB.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1, `retire`=1 → FETCH.
- **MEMWRITE:** `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1.
  - `MemWrite` is held for every stall cycle.
  - On `mem_ready` the FSM goes to FETCH and asserts `retire`.
- **EXECUTER:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10 → ALUWB.
- **EXECUTEI:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10 → ALUWB. `aludec` sees opb5=0, so funct7b5 never selects SUB here.
- **JAL:** `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCUpdate`=1 → ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1, `retire`=1 → FETCH.
- **BEQ:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `Branch`=1, `retire`=1 → FETCH.
- Opcode → `ImmSrc` mapping:
  - load, I-ALU → 00
  - store → 01
  - beq → 10
  - jal → 11
  - all others → 00

## Timing
- **Reset:** `reset_n`=0 at a rising edge forces state to FETCH. This applies from any state, including a stalled MEMWRITE; the write is abandoned.
- **Outputs during reset:** while `reset_n`=0, all strobes are 0 (`PCWrite`, `PCUpdate`, `IRWrite`, `RegWrite`, `MemWrite`, `Branch`, `illegal`, `retire`). Selects show the FETCH values: `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
- **Latency with `mem_ready` tied high (cycles from FETCH entry to retire):**
  - beq: 3
  - R-type, I-ALU, sw, jal: 4
  - lw: 5
  - illegal: 2
- **Stalls:** each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No strobe other than the held `MemWrite` fires during a stall.
- **`mem_ready` outside memory states:** ignored in every state except FETCH, MEMREAD and MEMWRITE.
- **PCWrite in BEQ:** PCWrite in BEQ is combinational from `Zero` in the same cycle.
- **Registered state:** the state register is the only storage. All outputs are combinational from the state, plus `op`, `Zero` and `mem_ready` where stated above.

## Structure
- The state encodings (4-bit, FETCH = 0) and opcode constants go in a shared header `ctrlops.v`, alongside the existing `aluops.v`.
- The `ALUOp` codes (00/01/10) are also defined in `ctrlops.v` so that `aludec` and `mainfsm` share them.
- The `ImmSrc` decode is a separate combinational sub-module, `immdec` (`op` → `ImmSrc`), instantiated inside `mainfsm`.

## Test plan
- **Reset:** `reset_n`=0 for 2 cycles from mid-MEMWRITE with `mem_ready`=0 → state is FETCH, `MemWrite`=0, all strobes are 0.
- **R-type (`op`=0110011), `mem_ready`=1:**
  - state sequence FETCH, DECODE, EXECUTER, ALUWB;
  - `ALUOp`=10 in EXECUTER;
  - `RegWrite`=1 and `retire`=1 in cycle 4 only.
- **lw (`op`=0000011) with `mem_ready` low for 3 cycles in MEMREAD:**
  - retires after 8 cycles;
  - `RegWrite` pulses once with `ResultSrc`=01.
- **sw with `mem_ready` low for 2 cycles:** `MemWrite`=1 for exactly 3 consecutive cycles, `ImmSrc`=01, then FETCH.
- **beq:**
  - with `Zero`=1: `PCWrite`=1 and `ALUOp`=01 in cycle 3;
  - with `Zero`=0: `PCWrite`=0;
  - both cases: 3-cycle retire.
- **Illegal opcode (`op`=0000000):** `illegal`=1 in DECODE, next state FETCH, no `RegWrite` and no `MemWrite` at any point.

Source files
------------

// File: rtl/mainfsm_pkg.sv
// Shared control constants for the multicycle RV32I control path:
// state encodings, opcodes, ALUOp codes and datapath select codes.
package mainfsm_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/mainfsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface mainfsm_if;
  import mainfsm_pkg::*;

  logic [OP_W-1:0]  op;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             Branch;
  logic             PCUpdate;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             AdrSrc;
  logic [SEL_W-1:0] ResultSrc;
  logic [SEL_W-1:0] ALUSrcA;
  logic [SEL_W-1:0] ALUSrcB;
  logic [SEL_W-1:0] ALUOp;
  logic [SEL_W-1:0] ImmSrc;
  logic             illegal;
  logic             retire;

  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, Branch, PCUpdate, IRWrite, RegWrite, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, retire
  );

  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, Branch, PCUpdate, IRWrite, RegWrite, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal, retire
  );

endinterface

// File: rtl/immdec.sv
// Immediate-format decode: opcode to ImmSrc, purely combinational.
module immdec
  import mainfsm_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle Moore control FSM: sequences fetch/decode/execute/memory/writeback
// with ready-handshaked memory accesses; outputs are decoded from the state.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  mainfsm_if.master bus
);

  state_e           state_q, state_d;
  logic             branch_c, pc_update_c, ir_write_c, reg_write_c, mem_write_c;
  logic             adr_src_c, illegal_c, retire_c;
  logic [SEL_W-1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic [SEL_W-1:0] imm_src;

  immdec u_immdec (
    .op      (bus.op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    branch_c     = 1'b0;
    pc_update_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    alu_op_c     = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURES;
        if (bus.mem_ready) begin
          ir_write_c  = 1'b1;
          pc_update_c = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            illegal_c = 1'b1;
            retire_c  = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      // MemWrite stays asserted through every stall cycle of the store
      S_MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a_c = SRCA_RS1;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c = SRCA_RS1;
        alu_op_c    = ALUOP_SUB;
        branch_c    = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // While reset is held, present quiet FETCH selects with every strobe low
    if (!reset_n) begin
      branch_c     = 1'b0;
      pc_update_c  = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      mem_write_c  = 1'b0;
      illegal_c    = 1'b0;
      retire_c     = 1'b0;
      adr_src_c    = 1'b0;
      result_src_c = RES_ALURES;
      alu_src_a_c  = SRCA_PC;
      alu_src_b_c  = SRCB_FOUR;
      alu_op_c     = ALUOP_ADD;
    end
  end

  assign bus.PCWrite   = (branch_c & bus.Zero) | pc_update_c;
  assign bus.Branch    = branch_c;
  assign bus.PCUpdate  = pc_update_c;
  assign bus.IRWrite   = ir_write_c;
  assign bus.RegWrite  = reg_write_c;
  assign bus.MemWrite  = mem_write_c;
  assign bus.AdrSrc    = adr_src_c;
  assign bus.ResultSrc = result_src_c;
  assign bus.ALUSrcA   = alu_src_a_c;
  assign bus.ALUSrcB   = alu_src_b_c;
  assign bus.ALUOp     = alu_op_c;
  assign bus.ImmSrc    = imm_src;
  assign bus.illegal   = illegal_c;
  assign bus.retire    = retire_c;

endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: an instruction-level model expands each instruction into
// its expected per-cycle control vectors, which are checked every cycle.
module tb_mainfsm;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mainfsm_if bus_if();

  mainfsm u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.master)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       pcwrite, branch, pcupdate, irwrite, regwrite, memwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, aluop, immsrc;
    logic       illegal, retire;
  } vec_t;

  typedef struct {
    vec_t e;
    logic rdy;
    logic zero;
  } cyc_t;

  cyc_t plan[$];
  vec_t obs[$];
  int   ret_at, rw_cnt, mw_cnt;
  logic [1:0] rw_res;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011: return 2'b00;
      7'b0100011:             return 2'b01;
      7'b1100011:             return 2'b10;
      7'b1101111:             return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  function automatic vec_t base(input logic [6:0] op);
    vec_t e = '0;
    e.immsrc = imm_of(op);
    return e;
  endfunction

  function automatic vec_t fetch_v(input logic [6:0] op, input logic ready);
    vec_t e = base(op);
    e.alusrcb   = 2'b10;
    e.resultsrc = 2'b10;
    if (ready) begin
      e.irwrite  = 1'b1;
      e.pcupdate = 1'b1;
      e.pcwrite  = 1'b1;
    end
    return e;
  endfunction

  function automatic vec_t actual();
    vec_t a;
    a.pcwrite   = bus_if.PCWrite;
    a.branch    = bus_if.Branch;
    a.pcupdate  = bus_if.PCUpdate;
    a.irwrite   = bus_if.IRWrite;
    a.regwrite  = bus_if.RegWrite;
    a.memwrite  = bus_if.MemWrite;
    a.adrsrc    = bus_if.AdrSrc;
    a.resultsrc = bus_if.ResultSrc;
    a.alusrca   = bus_if.ALUSrcA;
    a.alusrcb   = bus_if.ALUSrcB;
    a.aluop     = bus_if.ALUOp;
    a.immsrc    = bus_if.ImmSrc;
    a.illegal   = bus_if.illegal;
    a.retire    = bus_if.retire;
    return a;
  endfunction

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input vec_t req);
    vec_t a = actual();
    checks++;
    if (a !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, a, req);
    end
  endtask

  task automatic push(input vec_t e, input logic rdy, input logic zero);
    cyc_t c;
    c.e = e; c.rdy = rdy; c.zero = zero;
    plan.push_back(c);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Expand one instruction into its cycle-by-cycle expected control vectors
  task automatic plan_instr(input logic [6:0] op, input int fstall, input int mstall,
                            input logic zero);
    vec_t e;
    for (int i = 0; i < fstall; i++) push(fetch_v(op, 1'b0), 1'b0, rnd());
    push(fetch_v(op, 1'b1), 1'b1, rnd());
    e = base(op); e.alusrca = 2'b01; e.alusrcb = 2'b01;
    if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1101111, 7'b1100011})) begin
      e.illegal = 1'b1; e.retire = 1'b1;
      push(e, rnd(), rnd());
      return;
    end
    push(e, rnd(), rnd());
    if (op == 7'b0000011 || op == 7'b0100011) begin
      e = base(op); e.alusrca = 2'b10; e.alusrcb = 2'b01;
      push(e, rnd(), rnd());
      e = base(op); e.adrsrc = 1'b1;
      if (op == 7'b0100011) e.memwrite = 1'b1;
      for (int i = 0; i < mstall; i++) push(e, 1'b0, rnd());
      if (op == 7'b0100011) begin
        e.retire = 1'b1;
        push(e, 1'b1, rnd());
      end else begin
        push(e, 1'b1, rnd());
        e = base(op); e.resultsrc = 2'b01; e.regwrite = 1'b1; e.retire = 1'b1;
        push(e, rnd(), rnd());
      end
    end else if (op == 7'b1100011) begin
      e = base(op); e.alusrca = 2'b10; e.aluop = 2'b01;
      e.branch = 1'b1; e.retire = 1'b1; e.pcwrite = zero;
      push(e, rnd(), zero);
    end else begin
      e = base(op);
      if (op == 7'b0110011) begin
        e.alusrca = 2'b10; e.aluop = 2'b10;
      end else if (op == 7'b0010011) begin
        e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluop = 2'b10;
      end else begin
        e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcupdate = 1'b1; e.pcwrite = 1'b1;
      end
      push(e, rnd(), rnd());
      e = base(op); e.regwrite = 1'b1; e.retire = 1'b1;
      push(e, rnd(), rnd());
    end
  endtask

  // Drive and check planned cycles; entered and left just after a rising edge
  task automatic run_plan(input string name, input logic [6:0] op, input int limit);
    int n = 0;
    vec_t a;
    obs.delete();
    ret_at = 0; rw_cnt = 0; mw_cnt = 0; rw_res = 2'b11;
    bus_if.op = op;
    while (plan.size() > 0 && n < limit) begin
      cyc_t c = plan.pop_front();
      n++;
      bus_if.mem_ready = c.rdy;
      bus_if.Zero      = c.zero;
      @(negedge clk);
      check_vec($sformatf("%s cycle %0d", name, n), c.e);
      a = actual();
      obs.push_back(a);
      if (a.retire && ret_at == 0) ret_at = n;
      if (a.regwrite) begin rw_cnt++; rw_res = a.resultsrc; end
      if (a.memwrite) mw_cnt++;
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    reset_n = 1'b0;
    bus_if.op = 7'b0110011;
    bus_if.mem_ready = 1'b1;
    bus_if.Zero = 1'b1;
    rv = fetch_v(7'b0110011, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_vec("reset outputs", rv);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;

    plan_instr(7'b0110011, 0, 0, 1'b0); run_plan("rtype", 7'b0110011, 100);
    check_int("rtype latency", ret_at, 4);
    check_int("rtype regwrite count", rw_cnt, 1);
    check_int("rtype aluop in execute", int'(obs[2].aluop), 2);

    plan_instr(7'b0010011, 0, 0, 1'b0); run_plan("itype", 7'b0010011, 100);
    check_int("itype latency", ret_at, 4);

    plan_instr(7'b0000011, 0, 0, 1'b0); run_plan("lw", 7'b0000011, 100);
    check_int("lw latency", ret_at, 5);

    plan_instr(7'b0000011, 0, 3, 1'b0); run_plan("lw stall", 7'b0000011, 100);
    check_int("lw stall latency", ret_at, 8);
    check_int("lw stall regwrite count", rw_cnt, 1);
    check_int("lw stall resultsrc", int'(rw_res), 1);

    plan_instr(7'b0100011, 0, 0, 1'b0); run_plan("sw", 7'b0100011, 100);
    check_int("sw latency", ret_at, 4);

    plan_instr(7'b0100011, 0, 2, 1'b0); run_plan("sw stall", 7'b0100011, 100);
    check_int("sw stall memwrite cycles", mw_cnt, 3);
    check_int("sw stall latency", ret_at, 6);
    check_int("sw immsrc", int'(obs[3].immsrc), 1);

    plan_instr(7'b1101111, 0, 0, 1'b0); run_plan("jal", 7'b1101111, 100);
    check_int("jal latency", ret_at, 4);

    plan_instr(7'b1100011, 0, 0, 1'b1); run_plan("beq taken", 7'b1100011, 100);
    check_int("beq taken latency", ret_at, 3);
    check_int("beq taken pcwrite", int'(obs[2].pcwrite), 1);
    check_int("beq taken aluop", int'(obs[2].aluop), 1);

    plan_instr(7'b1100011, 0, 0, 1'b0); run_plan("beq not taken", 7'b1100011, 100);
    check_int("beq not taken latency", ret_at, 3);
    check_int("beq not taken pcwrite", int'(obs[2].pcwrite), 0);

    plan_instr(7'b0000000, 0, 0, 1'b0); run_plan("illegal", 7'b0000000, 100);
    check_int("illegal latency", ret_at, 2);
    check_int("illegal pulse in decode", int'(obs[1].illegal), 1);
    check_int("illegal regwrite count", rw_cnt, 0);
    check_int("illegal memwrite count", mw_cnt, 0);

    plan_instr(7'b0110011, 2, 0, 1'b0); run_plan("rtype fetch stall", 7'b0110011, 100);
    check_int("rtype fetch stall latency", ret_at, 6);

    // Abandon a stalled store with reset, then confirm a clean FETCH
    plan_instr(7'b0100011, 0, 5, 1'b0); run_plan("sw abort", 7'b0100011, 5);
    check_int("sw abort memwrite before reset", mw_cnt, 2);
    reset_n = 1'b0;
    bus_if.mem_ready = 1'b0;
    rv = fetch_v(7'b0100011, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_vec("reset from memwrite", rv);
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_vec("fetch after reset", rv);
    @(posedge clk); #1;

    plan_instr(7'b0110011, 0, 0, 1'b0); run_plan("rtype after reset", 7'b0110011, 100);
    check_int("rtype after reset latency", ret_at, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
